vc_arbiter_router: RTL and testbench

- Sits directly downstream of the VC0 and VC1 virtual-channel FIFOs in the PCI transmission layer.
- Arbitrates between the two channels with fixed priority to VC0.
- Pops one word from the winning FIFO and routes it to destination FIFO D0 or D1, selected by a destination bit in the word.
- Before popping, it applies backpressure using the destination FIFOs' almost-full flags and the VC FIFOs' registered head-preview outputs.

---
 rtl/vc_arbiter_router_pkg.sv | 11 +
 rtl/vc_arbiter_router_if.sv | 34 +++
 rtl/vc_arbiter_router_fixed_prio_arb2.sv | 26 ++
 rtl/vc_arbiter_router.sv | 75 +++++++
 tb/tb_vc_arbiter_router.sv | 132 +++++++++++++
 5 files changed

// File: rtl/vc_arbiter_router_pkg.sv
// vc_arbiter_router_pkg: shared state encoding, default widths and channel indices
package vc_arbiter_router_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    localparam int DATA_WIDTH_DEF = 6;
    localparam int DEST_BIT_DEF = 4;
    localparam int CNT_WIDTH_DEF = 8;
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;
    localparam logic D0 = 1'b0;
    localparam logic D1 = 1'b1;
endpackage

// File: rtl/vc_arbiter_router_if.sv
// vc_arbiter_router_if: VC FIFO inputs, destination FIFO outputs and status of the router
interface vc_arbiter_router_if #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH = 8
);
    logic empty_fifo_VC0;
    logic empty_fifo_VC1;
    logic [DATA_WIDTH-1:0] data_arbitro_VC0;
    logic [DATA_WIDTH-1:0] data_arbitro_VC1;
    logic [DATA_WIDTH-1:0] data_out_VC0;
    logic [DATA_WIDTH-1:0] data_out_VC1;
    logic almost_full_fifo_D0;
    logic almost_full_fifo_D1;
    logic pop_VC0;
    logic pop_VC1;
    logic push_D0;
    logic push_D1;
    logic [DATA_WIDTH-1:0] data_out_D;
    logic [CNT_WIDTH-1:0] cnt_D0;
    logic [CNT_WIDTH-1:0] cnt_D1;
    logic idle;

    modport master (
        input  empty_fifo_VC0, empty_fifo_VC1, data_arbitro_VC0, data_arbitro_VC1,
        input  data_out_VC0, data_out_VC1, almost_full_fifo_D0, almost_full_fifo_D1,
        output pop_VC0, pop_VC1, push_D0, push_D1, data_out_D, cnt_D0, cnt_D1, idle
    );

    modport slave (
        output empty_fifo_VC0, empty_fifo_VC1, data_arbitro_VC0, data_arbitro_VC1,
        output data_out_VC0, data_out_VC1, almost_full_fifo_D0, almost_full_fifo_D1,
        input  pop_VC0, pop_VC1, push_D0, push_D1, data_out_D, cnt_D0, cnt_D1, idle
    );
endinterface

// File: rtl/vc_arbiter_router_fixed_prio_arb2.sv
// vc_arbiter_router_fixed_prio_arb2: VC0-first select plus destination backpressure check
module vc_arbiter_router_fixed_prio_arb2
    import vc_arbiter_router_pkg::*;
(
    input  logic enable,
    input  logic empty0,
    input  logic empty1,
    input  logic dest0,
    input  logic dest1,
    input  logic af0,
    input  logic af1,
    output logic pop0,
    output logic pop1,
    output logic win,
    output logic dest,
    output logic go
);
    // strict priority: a non-empty VC0 always wins, even when its destination is blocked
    always_comb begin
        win = empty0 ? VC1 : VC0;
        dest = (win == VC0) ? dest0 : dest1;
        go = enable && !(empty0 && empty1) && !((dest == D1) ? af1 : af0);
        pop0 = go && (win == VC0);
        pop1 = go && (win == VC1);
    end
endmodule

// File: rtl/vc_arbiter_router.sv
// vc_arbiter_router: pops VC0/VC1 with fixed priority and routes each word to D0 or D1
module vc_arbiter_router
    import vc_arbiter_router_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
)(
    input logic clk,
    input logic reset,
    input logic init,
    vc_arbiter_router_if.master bus
);
    state_t state, next_state;
    logic clear, win, dest, go, lat_vc, lat_dest;
    logic [DATA_WIDTH-1:0] captured;

    assign clear = !reset || !init;
    assign captured = (lat_vc == VC0) ? bus.data_out_VC0 : bus.data_out_VC1;
    assign bus.idle = (state == IDLE) && bus.empty_fifo_VC0 && bus.empty_fifo_VC1;

    vc_arbiter_router_fixed_prio_arb2 u_arb (
        .enable (state == IDLE && !clear),
        .empty0 (bus.empty_fifo_VC0),
        .empty1 (bus.empty_fifo_VC1),
        .dest0  (bus.data_arbitro_VC0[DEST_BIT]),
        .dest1  (bus.data_arbitro_VC1[DEST_BIT]),
        .af0    (bus.almost_full_fifo_D0),
        .af1    (bus.almost_full_fifo_D1),
        .pop0   (bus.pop_VC0),
        .pop1   (bus.pop_VC1),
        .win    (win),
        .dest   (dest),
        .go     (go)
    );

    // a pop moves to WAIT for the FIFO read latency; WAIT always returns to IDLE
    always_comb begin
        next_state = IDLE;
        if (state == IDLE && go) next_state = WAIT;
    end

    // state register, cleared by reset or soft init
    always_ff @(posedge clk) begin
        state <= clear ? IDLE : next_state;
    end

    // remember which VC was popped and where its word goes; the preview decides, not the data
    always_ff @(posedge clk) begin
        if (go) begin
            lat_vc <= win;
            lat_dest <= dest;
        end
    end

    // capture the popped word and push it for one cycle, counting words per destination
    always_ff @(posedge clk) begin
        if (clear) begin
            bus.push_D0 <= 1'b0;
            bus.push_D1 <= 1'b0;
            bus.data_out_D <= '0;
            bus.cnt_D0 <= '0;
            bus.cnt_D1 <= '0;
        end else if (state == WAIT) begin
            bus.data_out_D <= captured;
            bus.push_D0 <= (lat_dest == D0);
            bus.push_D1 <= (lat_dest == D1);
            if (lat_dest == D0) bus.cnt_D0 <= bus.cnt_D0 + CNT_WIDTH'(1);
            else bus.cnt_D1 <= bus.cnt_D1 + CNT_WIDTH'(1);
        end else begin
            bus.push_D0 <= 1'b0;
            bus.push_D1 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vc_arbiter_router.sv
// tb_vc_arbiter_router: directed cycle-by-cycle vectors plus a counter-wrap sequence
module tb_vc_arbiter_router;
    localparam logic [5:0] W = 6'b010011;
    localparam logic [5:0] X = 6'b000101;

    typedef struct {
        logic rs, in, e0, e1;
        logic [5:0] p0, p1, d0, d1;
        logic a0, a1;
        logic pp0, pp1, ps0, ps1;
        logic [5:0] dt;
        logic [7:0] c0, c1;
        logic id;
    } vec_t;

    logic clk = 1'b0;
    logic reset, init;
    int tests = 0;
    int fails = 0;
    int row = 0;
    vec_t v[32];

    vc_arbiter_router_if bus ();

    vc_arbiter_router dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t r(input logic rs, in, e0, e1, input logic [5:0] p0, p1, d0, d1,
                               input logic a0, a1, pp0, pp1, ps0, ps1, input logic [5:0] dt,
                               input logic [7:0] c0, c1, input logic id);
        vec_t t;
        t.rs = rs; t.in = in; t.e0 = e0; t.e1 = e1;
        t.p0 = p0; t.p1 = p1; t.d0 = d0; t.d1 = d1;
        t.a0 = a0; t.a1 = a1;
        t.pp0 = pp0; t.pp1 = pp1; t.ps0 = ps0; t.ps1 = ps1;
        t.dt = dt; t.c0 = c0; t.c1 = c1; t.id = id;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset = t.rs; init = t.in;
        bus.empty_fifo_VC0 = t.e0; bus.empty_fifo_VC1 = t.e1;
        bus.data_arbitro_VC0 = t.p0; bus.data_arbitro_VC1 = t.p1;
        bus.data_out_VC0 = t.d0; bus.data_out_VC1 = t.d1;
        bus.almost_full_fifo_D0 = t.a0; bus.almost_full_fifo_D1 = t.a1;
    endtask

    initial begin
        v[0]  = r(0,1,0,1, W,X,X,X, 0,0, 0,0,0,0, 0, 0,0, 0);
        v[1]  = r(0,1,0,1, W,X,X,X, 0,0, 0,0,0,0, 0, 0,0, 0);
        v[2]  = r(1,0,0,1, W,X,X,X, 0,0, 0,0,0,0, 0, 0,0, 0);
        v[3]  = r(1,0,0,1, W,X,X,X, 0,0, 0,0,0,0, 0, 0,0, 0);
        v[4]  = r(1,1,0,1, W,X,X,X, 0,0, 1,0,0,0, 0, 0,0, 0);
        v[5]  = r(1,1,1,1, W,X,W,X, 0,0, 0,0,0,0, 0, 0,0, 0);
        v[6]  = r(1,1,1,1, W,X,W,X, 0,0, 0,0,0,1, W, 0,1, 1);
        v[7]  = r(1,1,1,1, W,X,W,X, 0,0, 0,0,0,0, W, 0,1, 1);
        v[8]  = r(1,1,0,0, X,W,W,X, 0,0, 1,0,0,0, W, 0,1, 0);
        v[9]  = r(1,1,0,0, X,W,X,W, 0,0, 0,0,0,0, W, 0,1, 0);
        v[10] = r(1,1,0,0, X,W,X,W, 0,0, 1,0,1,0, X, 1,1, 0);
        v[11] = r(1,1,0,0, X,W,X,W, 0,0, 0,0,0,0, X, 1,1, 0);
        v[12] = r(1,1,0,0, X,W,X,W, 0,0, 1,0,1,0, X, 2,1, 0);
        v[13] = r(1,1,0,0, X,W,X,W, 0,0, 0,0,0,0, X, 2,1, 0);
        v[14] = r(1,1,1,0, X,W,X,W, 0,0, 0,1,1,0, X, 3,1, 0);
        v[15] = r(1,1,1,1, X,W,X,W, 0,0, 0,0,0,0, X, 3,1, 0);
        v[16] = r(1,1,1,1, X,W,X,W, 0,0, 0,0,0,1, W, 3,2, 1);
        for (int i = 17; i < 22; i++) v[i] = r(1,1,0,0, X,W,X,W, 1,0, 0,0,0,0, W, 3,2, 0);
        v[22] = r(1,1,0,0, X,W,X,W, 0,0, 1,0,0,0, W, 3,2, 0);
        v[23] = r(1,1,0,0, X,W,X,W, 0,0, 0,0,0,0, W, 3,2, 0);
        v[24] = r(1,1,1,1, X,W,X,W, 0,0, 0,0,1,0, X, 4,2, 1);
        v[25] = r(1,1,0,1, W,X,X,X, 0,0, 1,0,0,0, X, 4,2, 0);
        v[26] = r(1,1,1,1, W,X,X,X, 0,0, 0,0,0,0, X, 4,2, 0);
        v[27] = r(1,1,1,1, W,X,X,X, 0,0, 0,0,0,1, X, 4,3, 1);
        v[28] = r(1,1,0,0, W,X,X,X, 0,1, 0,0,0,0, X, 4,3, 0);
        v[29] = r(1,1,0,0, X,X,X,X, 0,0, 1,0,0,0, X, 4,3, 0);
        v[30] = r(0,1,0,0, X,X,X,X, 0,0, 0,0,0,0, X, 4,3, 0);
        v[31] = r(1,1,1,1, X,X,X,X, 0,0, 0,0,0,0, 0, 0,0, 1);

        drive(v[0]);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            row = i;
            @(negedge clk);
            drive(v[i]);
            #1;
            check("pop_VC0", bus.pop_VC0, v[i].pp0);
            check("pop_VC1", bus.pop_VC1, v[i].pp1);
            check("push_D0", bus.push_D0, v[i].ps0);
            check("push_D1", bus.push_D1, v[i].ps1);
            check("data_out_D", bus.data_out_D, v[i].dt);
            check("cnt_D0", bus.cnt_D0, v[i].c0);
            check("cnt_D1", bus.cnt_D1, v[i].c1);
            check("idle", bus.idle, v[i].id);
        end

        row = 100;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.empty_fifo_VC0 = 1'b0;
            bus.data_arbitro_VC0 = X;
            #1;
            check("wrap_pop_VC0", bus.pop_VC0, 1'b1);
            @(negedge clk);
            bus.empty_fifo_VC0 = 1'b1;
            bus.data_out_VC0 = X;
            #1;
            if (i == 255) check("wrap_cnt_D0_255", bus.cnt_D0, 8'd255);
        end
        @(negedge clk);
        #1;
        check("wrap_push_D0", bus.push_D0, 1'b1);
        check("wrap_cnt_D0", bus.cnt_D0, 8'd0);
        check("wrap_cnt_D1", bus.cnt_D1, 8'd0);
        check("wrap_idle", bus.idle, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
